// File: rtl/booth_ctrl.sv
// Sequencing front-end for the radix-2 Booth multiplier core: takes an operand
// pair, clears and loads the core, waits out its iterations, returns the product.
module booth_ctrl #(
  parameter int WIDTH      = 16,
  parameter int STEP_CNT_W = 5
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic [WIDTH-1:0]     a_in,
  input  logic [WIDTH-1:0]     b_in,
  output logic                 res_valid,
  input  logic                 res_ready,
  output logic [2*WIDTH-1:0]   result,
  output logic                 core_reset,
  output logic                 core_load,
  output logic [WIDTH-1:0]     core_M,
  output logic [WIDTH-1:0]     core_Q,
  input  logic [2*WIDTH-1:0]   core_P
);

  localparam logic [2:0] IDLE = 3'd0;
  localparam logic [2:0] CLR  = 3'd1;
  localparam logic [2:0] LOAD = 3'd2;
  localparam logic [2:0] RUN  = 3'd3;
  localparam logic [2:0] CAPT = 3'd4;
  localparam logic [2:0] DONE = 3'd5;

  localparam logic [STEP_CNT_W-1:0] LAST_STEP = STEP_CNT_W'(WIDTH - 1);
  localparam logic [STEP_CNT_W-1:0] STEP_ONE  = STEP_CNT_W'(1);

  logic [2:0]            state;
  logic [WIDTH-1:0]      a_reg;
  logic [WIDTH-1:0]      b_reg;
  logic [STEP_CNT_W-1:0] counter;

  // Core strobes are decoded from the registered state so they are glitch-free.
  assign core_reset = reset | (state == CLR);
  assign core_load  = (state == LOAD);
  assign core_M     = a_reg;
  assign core_Q     = b_reg;
  assign req_ready  = (state == IDLE) & ~reset;

  // Operation sequencer, operand latches and result register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      a_reg     <= '0;
      b_reg     <= '0;
      result    <= '0;
      res_valid <= 1'b0;
      counter   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid) begin
            a_reg <= a_in;
            b_reg <= b_in;
            state <= CLR;
          end else begin
            state <= IDLE;
          end
        end
        CLR: begin
          state <= LOAD;
        end
        LOAD: begin
          counter <= '0;
          state   <= RUN;
        end
        RUN: begin
          counter <= counter + STEP_ONE;
          if (counter == LAST_STEP) begin
            state <= CAPT;
          end else begin
            state <= RUN;
          end
        end
        CAPT: begin
          result    <= core_P;
          res_valid <= 1'b1;
          state     <= DONE;
        end
        DONE: begin
          // result is left untouched after the handshake.
          if (res_ready) begin
            res_valid <= 1'b0;
            state     <= IDLE;
          end else begin
            state <= DONE;
          end
        end
        default: begin
          res_valid <= 1'b0;
          state     <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_booth_ctrl.sv
// Scoreboard bench for booth_ctrl with a behavioural Booth core model that only
// produces the true product after a reset, a load and 16 further cycles.
module tb_booth_ctrl;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [15:0] a_in = 16'h0000;
  logic [15:0] b_in = 16'h0000;
  logic        res_valid;
  logic        res_ready = 1'b1;
  logic [31:0] result;
  logic        core_reset;
  logic        core_load;
  logic [15:0] core_M;
  logic [15:0] core_Q;
  logic [31:0] core_P;

  booth_ctrl #(.WIDTH(16), .STEP_CNT_W(5)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
    .a_in(a_in), .b_in(b_in), .res_valid(res_valid), .res_ready(res_ready),
    .result(result), .core_reset(core_reset), .core_load(core_load),
    .core_M(core_M), .core_Q(core_Q), .core_P(core_P)
  );

  always #5 clk = ~clk;

  int     checks = 0;
  int     errors = 0;
  longint cyc = 0;
  longint last_acc = 0;
  longint last_hs = 0;
  int     nhs = 0;
  bit     busy = 1'b0;
  bit     prev_rv = 1'b0;
  bit     prev_hs = 1'b0;
  bit     prev_cr = 1'b0;
  bit     rr_rand = 1'b0;
  logic [31:0] pend_exp = 32'h0;

  typedef struct {
    logic [31:0] res;
    logic [15:0] m;
    logic [15:0] q;
    longint      acc;
  } exp_t;
  exp_t sb[$];

  function automatic logic [31:0] prod(input logic [15:0] a, input logic [15:0] b);
    int sa;
    int sb_;
    sa  = $signed(a);
    sb_ = $signed(b);
    return 32'(sa * sb_);
  endfunction

  task automatic check(input bit ok, input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at cycle %0d", name, act, exp, cyc);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Behavioural core: needs reset before load, then 16 steps to finish.
  logic [15:0] cm = 16'h0;
  logic [15:0] cq = 16'h0;
  int          ccnt = 0;
  bit          cloaded = 1'b0;
  bit          cclean = 1'b0;
  bit          cbad = 1'b0;
  always @(posedge clk) begin
    if (core_reset) begin
      ccnt <= 0; cclean <= 1'b1; cloaded <= 1'b0; cbad <= 1'b0;
    end else if (core_load) begin
      cm <= core_M; cq <= core_Q; ccnt <= 0; cloaded <= 1'b1;
      cbad <= !cclean; cclean <= 1'b0;
    end else if (cloaded && ccnt < 16) begin
      ccnt <= ccnt + 1;
    end
  end
  assign core_P = (cloaded && !cbad && ccnt == 16) ? prod(cm, cq)
                                                   : (~prod(cm, cq) ^ 32'(ccnt));

  // Monitor: samples on the falling edge, predicts the next rising edge.
  always @(negedge clk) begin
    if (reset) begin
      check(core_reset == 1'b1, "core_reset_in_reset", 32'(core_reset), 32'h1);
      check(req_ready == 1'b0, "req_ready_in_reset", 32'(req_ready), 32'h0);
      sb.delete();
      busy    = 1'b0;
      prev_rv = 1'b0;
      prev_hs = 1'b0;
    end else begin
      check(!(core_reset && core_load), "strobes_overlap", {core_reset, core_load}, 32'h0);
      check(req_ready == !busy, "req_ready", 32'(req_ready), 32'(!busy));
      if (core_load)
        check(prev_cr == 1'b1, "load_after_reset", 32'(prev_cr), 32'h1);
      if (busy && sb.size() > 0)
        check(core_M == sb[$].m && core_Q == sb[$].q, "operand_hold",
              {core_M, core_Q}, {sb[$].m, sb[$].q});
      if (res_valid) begin
        if (sb.size() == 0) begin
          check(1'b0, "unexpected_res_valid", result, 32'h0);
        end else begin
          check(result == sb[0].res, "result", result, sb[0].res);
          if (!prev_rv)
            check(cyc - sb[0].acc == 19, "latency", 32'(cyc - sb[0].acc), 32'd19);
        end
      end else if (prev_rv) begin
        check(prev_hs, "res_valid_dropped", 32'(res_valid), 32'h1);
      end
      prev_rv = res_valid;
      prev_hs = res_valid && res_ready;
      if (res_valid && res_ready) begin
        if (sb.size() > 0) void'(sb.pop_front());
        busy    = 1'b0;
        nhs++;
        last_hs = cyc + 1;
      end
      if (req_valid && req_ready) begin
        sb.push_back('{res: pend_exp, m: a_in, q: b_in, acc: cyc + 1});
        busy     = 1'b1;
        last_acc = cyc + 1;
      end
    end
    prev_cr = core_reset;
  end

  // Random consumer back-pressure when enabled.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (rr_rand) res_ready = 1'($urandom_range(0, 1));
    end
  end

  task automatic issue(input logic [15:0] a, input logic [15:0] b,
                       input logic [31:0] exp, input int hold);
    bit ok;
    ok = 1'b0;
    @(posedge clk); #1;
    pend_exp  = exp;
    req_valid = 1'b1;
    a_in      = a;
    b_in      = b;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (req_ready) begin ok = 1'b1; break; end
    end
    if (!ok) check(1'b0, "accept_timeout", 32'h0, 32'h1);
    @(posedge clk); #1;
    // Keep pushing fresh operands into a busy block; they must be ignored.
    for (int i = 0; i < hold; i++) begin
      a_in = 16'($urandom);
      b_in = 16'($urandom);
      @(posedge clk); #1;
    end
    req_valid = 1'b0;
  endtask

  task automatic wait_idle();
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (!busy && sb.size() == 0) begin ok = 1'b1; break; end
    end
    if (!ok) check(1'b0, "idle_timeout", 32'(sb.size()), 32'h0);
  endtask

  initial begin
    int hs0;
    bit seen;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check(result == 32'h0, "reset_result", result, 32'h0);
    check(res_valid == 1'b0, "reset_res_valid", 32'(res_valid), 32'h0);
    check(core_load == 1'b0, "reset_core_load", 32'(core_load), 32'h0);
    check({core_M, core_Q} == 32'h0, "reset_operands", {core_M, core_Q}, 32'h0);

    issue(16'd3, 16'd5, 32'h0000000F, 0);           wait_idle();
    issue(16'hFFFE, 16'd7, 32'hFFFFFFF2, 0);        wait_idle();
    issue(16'h7FFF, 16'h7FFF, 32'h3FFF0001, 0);     wait_idle();
    issue(16'h1234, 16'h0000, 32'h00000000, 0);     wait_idle();
    issue(16'h8000, 16'h0002, prod(16'h8000, 16'h0002), 0); wait_idle();

    // Back-pressure: consumer stalls 5 cycles after res_valid.
    res_ready = 1'b0;
    hs0 = nhs;
    issue(16'hFFFF, 16'hFFFF, 32'h00000001, 0);
    seen = 1'b0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (res_valid) begin seen = 1'b1; break; end
    end
    check(seen, "bp_res_valid_seen", 32'(seen), 32'h1);
    repeat (5) @(posedge clk);
    #1 res_ready = 1'b1;
    wait_idle();
    check(nhs - hs0 == 1, "bp_one_handshake", 32'(nhs - hs0), 32'h1);

    // Busy rejection with changing operands on a held req_valid.
    issue(16'h0102, 16'hFFF0, 32'hFFFFEFE0, 15);    wait_idle();

    // Mid-RUN reset at step 8, then a fresh operation.
    hs0 = nhs;
    issue(16'd100, 16'd200, 32'd20000, 0);
    repeat (9) @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0;
    repeat (25) @(negedge clk);
    check(nhs == hs0, "abort_no_result", 32'(nhs - hs0), 32'h0);
    issue(16'd6, 16'hFFFD, 32'hFFFFFFEE, 0);        wait_idle();

    // Back-to-back requests with res_ready high.
    issue(16'd11, 16'd13, 32'd143, 0);
    issue(16'hFFF9, 16'd9, 32'hFFFFFFC1, 0);
    check(last_acc == last_hs + 1, "b2b_accept_gap", 32'(last_acc - last_hs), 32'h1);
    wait_idle();

    // Randomised traffic with random consumer stalls.
    rr_rand = 1'b1;
    for (int n = 0; n < 25; n++) begin
      logic [15:0] ra;
      logic [15:0] rb;
      ra = 16'($urandom);
      rb = 16'($urandom);
      issue(ra, rb, prod(ra, rb), 0);
    end
    wait_idle();
    rr_rand = 1'b0;
    #1 res_ready = 1'b1;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
